// File: rtl/reflet_8bit_ctrl_rom.sv
// Self-contained 8-bit UART controller: streams a fixed ROM banner after reset,
// then echoes received bytes, answers '?' with the GPIO inputs and halts on 0x04.
module reflet_8bit_ctrl_rom #(
    parameter int unsigned CLK_PER_BIT = 11
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        rx,
    input  logic [15:0] gpi,
    output logic        tx,
    output logic [15:0] gpo,
    output logic [7:0]  debug,
    output logic        quit
);
    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {BANNER = 2'd0, RUN = 2'd1, SEND = 2'd2, HALT = 2'd3} ctrl_state_t;

    // ---------------- receiver ----------------
    rx_state_t     rx_state, rx_state_n;
    logic          rx_s1, rx_s2, rx_d;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_done, rx_valid;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_d && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == HALF_M1) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == FULL_M1) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == FULL_M1) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    rx_done    = 1'b1;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_WAIT;
                end
            end
            RX_WAIT: begin
                rx_cnt_n = '0;
                if (rx_s2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_valid <= rx_done;
        end
    end

    // ---------------- transmitter ----------------
    logic          tx_busy, tx_start, tx_last, tx_ready;
    logic [7:0]    tx_data;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bitn;
    logic [CW-1:0] tx_cnt;

    // Ready during the final stop-bit cycle so the next frame follows with no gap.
    assign tx_last  = tx_busy && (tx_cnt == FULL_M1) && (tx_bitn == 4'd0);
    assign tx_ready = !tx_busy || tx_last;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_bitn  <= '0;
            tx_cnt   <= '0;
        end else if (tx_start) begin
            tx       <= 1'b0;
            tx_shift <= {1'b1, tx_data};
            tx_bitn  <= 4'd9;
            tx_cnt   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == FULL_M1) begin
                tx_cnt <= '0;
                if (tx_bitn == 4'd0) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bitn  <= tx_bitn - 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- controller ----------------
    ctrl_state_t state, state_n;
    logic [3:0]  rom_ptr;
    logic [7:0]  rom_data, holding, gpi_lo, gpo_lo, gpo_cnt;
    logic        holding_full, halt_pend;
    logic        consume, rom_adv, latch_gpi, halt_set;

    always_comb begin
        case (rom_ptr)
            4'd0:    rom_data = 8'h52;
            4'd1:    rom_data = 8'h65;
            4'd2:    rom_data = 8'h66;
            4'd3:    rom_data = 8'h6C;
            4'd4:    rom_data = 8'h65;
            4'd5:    rom_data = 8'h74;
            4'd6:    rom_data = 8'h0D;
            4'd7:    rom_data = 8'h0A;
            default: rom_data = 8'h00;
        endcase
    end

    always_comb begin
        state_n   = state;
        tx_start  = 1'b0;
        tx_data   = '0;
        consume   = 1'b0;
        rom_adv   = 1'b0;
        latch_gpi = 1'b0;
        halt_set  = 1'b0;
        case (state)
            BANNER: begin
                if (rom_data == 8'h00) begin
                    state_n = RUN;
                end else if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_data  = rom_data;
                    if (rom_ptr == 4'hF) state_n = RUN;
                    else                 rom_adv = 1'b1;
                end
            end
            RUN: begin
                if (halt_pend) begin
                    if (tx_ready) state_n = HALT;
                end else if (holding_full && tx_ready) begin
                    consume  = 1'b1;
                    tx_start = 1'b1;
                    tx_data  = holding;
                    if (holding == 8'h3F) begin
                        // High byte goes out straight away; low byte is latched for SEND.
                        tx_data   = gpi[15:8];
                        latch_gpi = 1'b1;
                        state_n   = SEND;
                    end else if (holding == 8'h04) begin
                        halt_set = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_data  = gpi_lo;
                    state_n  = RUN;
                end
            end
            HALT: consume = holding_full;
            default: state_n = BANNER;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state        <= BANNER;
            rom_ptr      <= '0;
            holding      <= '0;
            holding_full <= 1'b0;
            halt_pend    <= 1'b0;
            gpi_lo       <= '0;
            gpo_lo       <= '0;
            gpo_cnt      <= '0;
        end else begin
            state <= state_n;
            if (rom_adv)   rom_ptr   <= rom_ptr + 4'd1;
            if (latch_gpi) gpi_lo    <= gpi[7:0];
            if (halt_set)  halt_pend <= 1'b1;
            // A freshly accepted byte wins over a same-cycle consumption.
            if (rx_valid) begin
                holding      <= rx_shift;
                holding_full <= 1'b1;
                gpo_lo       <= rx_shift;
                gpo_cnt      <= gpo_cnt + 8'd1;
            end else if (consume) begin
                holding_full <= 1'b0;
            end
        end
    end

    assign gpo   = {gpo_cnt, gpo_lo};
    assign debug = {state, 1'b0, holding_full, rom_ptr};
    assign quit  = (state == HALT);
endmodule

// File: tb/tb_reflet_8bit_ctrl_rom.sv
// Scoreboard bench for reflet_8bit_ctrl_rom: expected TX bytes are queued as
// stimulus is applied and checked as a UART monitor decodes frames from tx.
module tb_reflet_8bit_ctrl_rom;
    localparam int unsigned CPB = 11;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] gpi = '0;
    logic        tx;
    logic [15:0] gpo;
    logic [7:0]  debug;
    logic        quit;

    reflet_8bit_ctrl_rom #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .reset_in(reset_in), .rx(rx), .gpi(gpi),
        .tx(tx), .gpo(gpo), .debug(debug), .quit(quit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART monitor on tx, sampled on the falling clock edge
    logic       tx_prev = 1'b1;
    logic       m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] m_exp;
    logic       quit_prev = 1'b0;
    int         quit_cyc = -1;

    always @(negedge clk) begin
        if (!reset_in) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx_prev && !tx) begin
                m_active = 1'b1;
                m_k = 0;
                starts.push_back(cyc);
            end
        end else begin
            m_k++;
            if (m_k == CPB / 2) begin
                check("tx_start_bit", tx, 1'b0);
            end else if (m_k > CPB / 2 && m_k < CPB / 2 + 9 * CPB && (m_k - CPB / 2) % CPB == 0) begin
                m_byte[(m_k - CPB / 2) / CPB - 1] = tx;
            end else if (m_k == CPB / 2 + 9 * CPB) begin
                check("tx_stop_bit", tx, 1'b1);
                check("tx_frame_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    check("tx_byte", m_byte, m_exp);
                end
                m_active = 1'b0;
            end
        end
        tx_prev = tx;
        if (quit && !quit_prev) quit_cyc = cyc;
        quit_prev = quit;
    end

    task automatic uart_send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || m_active) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_gpo(input string tag, input logic [15:0] exp, input int max_cyc);
        int n = 0;
        while (gpo !== exp && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, gpo, exp);
    endtask

    task automatic push_banner();
        logic [7:0] banner [8] = '{8'h52, 8'h65, 8'h66, 8'h6C, 8'h65, 8'h74, 8'h0D, 8'h0A};
        for (int i = 0; i < 8; i++) exp_q.push_back(banner[i]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"}, tx, 1'b1);
        check({tag, "_gpo"}, gpo, 16'h0000);
        check({tag, "_quit"}, quit, 1'b0);
        check({tag, "_debug"}, debug, 8'h00);
    endtask

    // Release reset, hold rx low 100 cycles during the banner: expect banner + 0x00 echo
    task automatic banner_with_rx_zero(input string tag);
        push_banner();
        exp_q.push_back(8'h00);
        starts.delete();
        @(negedge clk);
        reset_in = 1'b1;
        repeat (200) @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        wait_gpo({tag, "_gpo_zero_byte"}, 16'h0100, 40);
        wait_drain({tag, "_drain"}, 900);
        check({tag, "_frames"}, starts.size(), 9);
        if (starts.size() == 9) check({tag, "_echo_gap"}, starts[8] - starts[7], 110);
    endtask

    int rel;
    int n0;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset0");

        // clean banner
        push_banner();
        starts.delete();
        reset_in = 1'b1;
        rel = cyc;
        wait_drain("banner_drain", 1200);
        check("banner_frames", starts.size(), 8);
        if (starts.size() >= 8) begin
            check("banner_latency", (starts[0] - rel) <= 2, 1'b1);
            for (int i = 1; i < 8; i++) check("banner_gap", starts[i] - starts[i-1], 110);
            check("banner_span", starts[7] + 110 - starts[0], 880);
        end
        repeat (60) @(negedge clk);
        check("banner_no_extra", starts.size(), 8);
        check("banner_idle_tx", tx, 1'b1);
        check("banner_quit", quit, 1'b0);
        check("banner_gpo", gpo, 16'h0000);
        check("banner_debug", debug, 8'h48);

        // reset in the middle of the first banner frame
        reset_in = 1'b0;
        repeat (5) @(negedge clk);
        reset_in = 1'b1;
        repeat (50) @(negedge clk);
        check("midframe_tx_low", tx, 1'b0);
        #1 reset_in = 1'b0;
        #1 check("midframe_async_tx", tx, 1'b1);
        check("midframe_async_debug", debug, 8'h00);
        repeat (5) @(negedge clk);
        exp_q.delete();
        check_reset_values("midframe");

        banner_with_rx_zero("pass1");

        // 5-cycle reset after the echo, then the same sequence again
        repeat (10) @(negedge clk);
        reset_in = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check_reset_values("reset2");
        banner_with_rx_zero("pass2");

        // GPIO query
        repeat (20) @(negedge clk);
        n0 = starts.size();
        gpi = 16'hA55A;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        uart_send(8'h3F, 1'b1);
        gpi = 16'h0000;
        check("query_gpo", gpo, 16'h023F);
        wait_drain("query_drain", 400);
        check("query_frames", starts.size() - n0, 2);
        if (starts.size() == n0 + 2) check("query_gap", starts[n0+1] - starts[n0], 110);

        // framing error: stop bit held low
        n0 = starts.size();
        uart_send(8'h55, 1'b0);
        repeat (150) @(negedge clk);
        check("ferr_gpo", gpo, 16'h023F);
        check("ferr_no_echo", starts.size() - n0, 0);
        check("ferr_debug", debug, 8'h48);
        exp_q.push_back(8'h31);
        uart_send(8'h31, 1'b1);
        wait_gpo("after_ferr_gpo", 16'h0331, 20);
        wait_drain("after_ferr_drain", 300);
        check("after_ferr_frames", starts.size() - n0, 1);

        // 0x04 halts; 0x41 afterwards is received but never echoed
        repeat (20) @(negedge clk);
        n0 = starts.size();
        exp_q.push_back(8'h04);
        uart_send(8'h04, 1'b1);
        uart_send(8'h41, 1'b1);
        wait_gpo("halt_gpo", 16'h0541, 20);
        wait_drain("halt_drain", 300);
        repeat (150) @(negedge clk);
        check("halt_quit", quit, 1'b1);
        check("halt_frames", starts.size() - n0, 1);
        if (starts.size() > n0) check("quit_timing", quit_cyc - starts[n0], 110);
        check("halt_debug", debug, 8'hC8);
        check("halt_tx_idle", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
